uart_rx: RTL

- Serial UART receiver; sits directly downstream of Baud_Gen and consumes its Rx_clk oversampling strobe.
- Synchronises the asynchronous serial line, detects and validates the start bit, and samples each bit at mid-bit.
- Shifts in DATA_BITS data bits LSB first and checks the stop bit.
- Presents the received byte with a one-cycle valid pulse and error flags to the consumer (FIFO or host logic).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame/oversampling constants.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling on the Rx_clk oversampling strobe, LSB-first data, stop check.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_clk,
    input  logic                 Rx_serial,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 Rx_valid,
    output logic                 Rx_frame_err,
    output logic                 Rx_parity_err,
    output logic                 Rx_busy
);

    localparam int unsigned TW       = $clog2(OVERSAMPLE);
    localparam int unsigned BW       = $clog2(DATA_BITS);
    localparam int unsigned TICK_MID = OVERSAMPLE / 2 - 1;
    localparam int unsigned TICK_END = OVERSAMPLE - 1;

    logic                 rxs;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Rx_serial),
        .q     (rxs)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
`endif

    assign bit_end = (tick_q == TW'(TICK_END));

    // Next-state, counters and output pulses; everything except pulse clearing waits for a strobe.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (Rx_clk) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TW'(TICK_MID)) begin
                        tick_d = '0;
                        bit_d  = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (bit_end) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_d = tick_q + TW'(1);
                    if (bit_end) begin
                        tick_d  = '0;
                        par_d   = rxs;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (bit_end) begin
                        tick_d = '0;
                        data_d = shift_q;
                        if (rxs) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data bits plus parity bit must XOR to zero.
                            if (par_q != ^shift_q) perr_d = 1'b1;
                            else                   valid_d = 1'b1;
`else
                            valid_d = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign Rx_data      = data_q;
    assign Rx_valid     = valid_q;
    assign Rx_frame_err = ferr_q;
    assign Rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign Rx_parity_err = perr_q;
`else
    assign Rx_parity_err = 1'b0;
`endif

endmodule
